// File: rtl/decoder_2to4_pulse_pkg.sv
// Shared definitions for the 2-to-4 pulse decoder: code constants, FSM encoding
// and a small elaboration-time helper.
package decoder_2to4_pulse_pkg;

    localparam logic [1:0] CODE_A = 2'b11;
    localparam logic [1:0] CODE_B = 2'b10;
    localparam logic [1:0] CODE_C = 2'b01;
    localparam logic [1:0] CODE_D = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PULSE = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    function automatic int max_of(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/decoder_2to4.sv
// Combinational 2-bit code to one-hot {a,b,c,d} decode with enable.
module decoder_2to4
    import decoder_2to4_pulse_pkg::*;
(
    input  logic [1:0] code,
    input  logic       en,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d
);

    always_comb begin
        a = 1'b0;
        b = 1'b0;
        c = 1'b0;
        d = 1'b0;
        if (en) begin
            case (code)
                CODE_A:  a = 1'b1;
                CODE_B:  b = 1'b1;
                CODE_C:  c = 1'b1;
                default: d = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/decoder_2to4_pulse.sv
// Accepts a 2-bit code over valid/ready and emits the matching one-hot line as a
// PULSE_LEN-cycle strobe, followed by a GAP_LEN-cycle idle gap.
module decoder_2to4_pulse
    import decoder_2to4_pulse_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic in_valid,
    output logic in_ready,
    input  logic e1,
    input  logic e0,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(max_of(max_of(PULSE_LEN, GAP_LEN), 2));
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] GAP_LD   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      code_q, code_n;
    logic            done_n;
    logic            a_n, b_n, c_n, d_n;

    assign in_ready = (state == ST_IDLE) & en;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = code_q;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    code_n  = {e1, e0};
                    state_n = ST_PULSE;
                    cnt_n   = PULSE_LD;
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    if (GAP_LEN > 0) begin
                        state_n = ST_GAP;
                        cnt_n   = GAP_LD;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == '0) state_n = ST_IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next-state values and registered, so the line rises
    // in the cycle right after the accepting edge while staying glitch-free.
    assign done_n = (state_n == ST_PULSE) && (cnt_n == '0);

    decoder_2to4 u_core (
        .code (code_n),
        .en   (state_n == ST_PULSE),
        .a    (a_n),
        .b    (b_n),
        .c    (c_n),
        .d    (d_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            code_q <= '0;
            a      <= 1'b0;
            b      <= 1'b0;
            c      <= 1'b0;
            d      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            code_q <= code_n;
            a      <= a_n;
            b      <= b_n;
            c      <= c_n;
            d      <= d_n;
            busy   <= (state_n != ST_IDLE);
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_decoder_2to4_pulse.sv
// Scoreboard bench: two decoders (4/1 and 1/0 pulse/gap) share stimulus; every
// accepted code pushes its expected per-cycle output frames, popped each cycle.
module tb_decoder_2to4_pulse;

    localparam int P0 = 4, G0 = 1;
    localparam int P1 = 1, G1 = 0;

    logic clk = 1'b0;
    logic rst_n, en, in_valid;
    logic [1:0] code;
    logic rdy0, a0, b0, c0, d0, busy0, done0;
    logic rdy1, a1, b1, c1, d1, busy1, done1;

    int checks = 0;
    int errors = 0;

    // frame = {a,b,c,d,busy,done}
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    bit idle0 = 1'b1;
    bit idle1 = 1'b1;

    always #5 clk = ~clk;

    decoder_2to4_pulse #(.PULSE_LEN(P0), .GAP_LEN(G0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy0),
        .e1(code[1]), .e0(code[0]), .a(a0), .b(b0), .c(c0), .d(d0),
        .busy(busy0), .done(done0)
    );

    decoder_2to4_pulse #(.PULSE_LEN(P1), .GAP_LEN(G1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy1),
        .e1(code[1]), .e0(code[0]), .a(a1), .b(b1), .c(c1), .d(d1),
        .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot(input logic [1:0] c);
        logic [3:0] one;
        one = 4'b0001;
        return one << c;
    endfunction

    // Handshake: the expected-idle flag from the previous negedge decides acceptance.
    always @(posedge clk) begin
        if (rst_n && in_valid && en && idle0) begin
            for (int i = 0; i < P0; i++) q0.push_back({onehot(code), 1'b1, i == P0 - 1});
            for (int i = 0; i < G0; i++) q0.push_back(6'b000010);
        end
        if (rst_n && in_valid && en && idle1) begin
            for (int i = 0; i < P1; i++) q1.push_back({onehot(code), 1'b1, i == P1 - 1});
            for (int i = 0; i < G1; i++) q1.push_back(6'b000010);
        end
    end

    always @(negedge clk) begin
        logic [5:0] e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            idle0 = 1'b1;
            idle1 = 1'b1;
            chk("rst0", {1'b0, rdy0, a0, b0, c0, d0, busy0, done0}, {1'b0, en, 6'b0});
            chk("rst1", {1'b0, rdy1, a1, b1, c1, d1, busy1, done1}, {1'b0, en, 6'b0});
        end else begin
            idle0 = (q0.size() == 0);
            e = idle0 ? 6'b0 : q0.pop_front();
            chk("out0", {1'b0, rdy0, a0, b0, c0, d0, busy0, done0}, {1'b0, en & idle0, e});
            idle1 = (q1.size() == 0);
            e = idle1 ? 6'b0 : q1.pop_front();
            chk("out1", {1'b0, rdy1, a1, b1, c1, d1, busy1, done1}, {1'b0, en & idle1, e});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; code = 2'b11;
        cyc(2);
        en = 1'b0;
        cyc(1);
        en = 1'b1;
        cyc(1);
        // valid held high: code 11 then 01, one accept per idle visit
        rst_n = 1'b1;
        cyc(1);
        code = 2'b01;
        cyc(14);
        in_valid = 1'b0;
        cyc(8);
        for (int k = 0; k < 4; k++) begin
            code = 2'(k);
            in_valid = 1'b1;
            cyc(1);
            in_valid = 1'b0;
            cyc(7);
        end
        // en dropped mid-pulse, valid toggling with unknown code bits
        code = 2'b10;
        in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = ~in_valid;
            code = 2'bxx;
            cyc(1);
        end
        in_valid = 1'b0;
        code = 2'b00;
        cyc(2);
        en = 1'b1;
        cyc(3);
        // async reset in the second pulse cycle
        code = 2'b11;
        in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        cyc(1);
        rst_n = 1'b0;
        #1;
        chk("arst0", {2'b0, a0, b0, c0, d0, busy0, done0}, 8'h00);
        chk("arst1", {2'b0, a1, b1, c1, d1, busy1, done1}, 8'h00);
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        chk("drain0", 8'(q0.size()), 8'h00);
        chk("drain1", 8'(q1.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
